// File: rtl/riscv_core.sv
// Single-cycle RV32I core with private instruction ROM and data RAM.
// One instruction retires per rising edge; fetch, decode, execute and memory read are combinational.
module riscv_core #(
  parameter int unsigned IMEM_DEPTH = 10,
  parameter int unsigned DMEM_DEPTH = 10
) (
  input logic clk,
  input logic rst
);

  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpReg    = 7'h33;

  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, pc_next;
  logic        rd_we;
  logic [31:0] rd_val;

  logic        is_reg;
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        alu_ok;
  logic        br_taken;

  logic [31:0]           dm_addr, dm_rdata, dm_wdata;
  logic [3:0]            dm_be;
  logic [DMEM_DEPTH-1:0] dm_idx;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  unused_addr;

  // Instruction ROM; contents are preloaded from outside the core.
  if (1'b1) begin : instr_mem
    logic [31:0] mem [2**IMEM_DEPTH];
    assign instr = mem[pc[IMEM_DEPTH+1:2]];
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;

  assign is_reg = (opcode == OpReg);
  assign alu_b  = is_reg ? rs2_val : imm_i;
  assign shamt  = alu_b[4:0];

  // Shared by OP and OP-IMM; alu_ok flags encodings with an unsupported funct7.
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (funct3)
      3'b000: begin
        alu_res = (is_reg && funct7 == 7'h20) ? rs1_val - alu_b : rs1_val + alu_b;
        alu_ok  = !is_reg || funct7 == 7'h00 || funct7 == 7'h20;
      end
      3'b001: begin
        alu_res = rs1_val << shamt;
        alu_ok  = (funct7 == 7'h00);
      end
      3'b010: begin
        alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
        alu_ok  = !is_reg || funct7 == 7'h00;
      end
      3'b011: begin
        alu_res = {31'd0, rs1_val < alu_b};
        alu_ok  = !is_reg || funct7 == 7'h00;
      end
      3'b100: begin
        alu_res = rs1_val ^ alu_b;
        alu_ok  = !is_reg || funct7 == 7'h00;
      end
      3'b101: begin
        alu_res = (funct7 == 7'h20) ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
        alu_ok  = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      3'b110: begin
        alu_res = rs1_val | alu_b;
        alu_ok  = !is_reg || funct7 == 7'h00;
      end
      default: begin
        alu_res = rs1_val & alu_b;
        alu_ok  = !is_reg || funct7 == 7'h00;
      end
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign dm_addr     = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
  assign dm_idx      = dm_addr[DMEM_DEPTH+1:2];
  assign ld_byte     = dm_rdata[{dm_addr[1:0], 3'b000} +: 8];
  assign ld_half     = dm_rdata[{dm_addr[1], 4'b0000} +: 16];
  assign unused_addr = ^dm_addr[31:DMEM_DEPTH+2];

  // Data RAM: combinational read, byte-enabled write, no writes while in reset.
  if (1'b1) begin : data_mem
    logic [31:0] mem [2**DMEM_DEPTH];
    assign dm_rdata = mem[dm_idx];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int b = 0; b < 4; b++) begin
          if (dm_be[b]) mem[dm_idx][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    pc_next  = pc_plus4;
    rd_we    = 1'b0;
    rd_val   = alu_res;
    dm_be    = 4'b0000;
    dm_wdata = '0;
    case (opcode)
      OpLui: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OpAuipc: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OpJal: begin
        rd_we   = 1'b1;
        rd_val  = pc_plus4;
        pc_next = pc + imm_j;
      end
      OpJalr: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc_plus4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OpBranch: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      OpLoad: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_val = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rd_val = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_val = dm_rdata;
          3'b100:  rd_val = {24'd0, ld_byte};
          3'b101:  rd_val = {16'd0, ld_half};
          default: rd_we  = 1'b0;
        endcase
      end
      OpStore: begin
        case (funct3)
          3'b000: begin
            dm_be    = 4'b0001 << dm_addr[1:0];
            dm_wdata = {4{rs2_val[7:0]}};
          end
          3'b001: begin
            dm_be    = dm_addr[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {2{rs2_val[15:0]}};
          end
          3'b010: begin
            dm_be    = 4'b1111;
            dm_wdata = rs2_val;
          end
          default: dm_be = 4'b0000;
        endcase
      end
      OpImm, OpReg: rd_we = alu_ok;
      default: rd_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: directed programs with literal expectations, then a random program,
// all checked every cycle against an instruction-level model of RV32I.
module tb_riscv_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_core #(
    .IMEM_DEPTH(10),
    .DMEM_DEPTH(10)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          chk_en      = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] prog [$];

  typedef enum {
    I_NOP, I_LUI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_OR, I_AND, I_SRL, I_SRA
  } mnem_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mnem_e decode(input logic [31:0] in);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = in[14:12];
    f7 = in[31:25];
    case (in[6:0])
      7'h37: return I_LUI;
      7'h17: return I_AUIPC;
      7'h6f: return I_JAL;
      7'h67: return (f3 == 3'd0) ? I_JALR : I_NOP;
      7'h63: case (f3)
        3'd0: return I_BEQ;   3'd1: return I_BNE;
        3'd4: return I_BLT;   3'd5: return I_BGE;
        3'd6: return I_BLTU;  3'd7: return I_BGEU;
        default: return I_NOP;
      endcase
      7'h03: case (f3)
        3'd0: return I_LB;  3'd1: return I_LH;  3'd2: return I_LW;
        3'd4: return I_LBU; 3'd5: return I_LHU;
        default: return I_NOP;
      endcase
      7'h23: case (f3)
        3'd0: return I_SB; 3'd1: return I_SH; 3'd2: return I_SW;
        default: return I_NOP;
      endcase
      7'h13: case (f3)
        3'd0: return I_ADDI;  3'd2: return I_SLTI; 3'd3: return I_SLTIU;
        3'd4: return I_XORI;  3'd6: return I_ORI;  3'd7: return I_ANDI;
        3'd1: return (f7 == 7'h00) ? I_SLLI : I_NOP;
        default: return (f7 == 7'h00) ? I_SRLI : (f7 == 7'h20) ? I_SRAI : I_NOP;
      endcase
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: return I_ADD;  3'd1: return I_SLL; 3'd2: return I_SLT; 3'd3: return I_SLTU;
            3'd4: return I_XOR;  3'd5: return I_SRL; 3'd6: return I_OR;  default: return I_AND;
          endcase
        end
        if (f7 == 7'h20 && f3 == 3'd0) return I_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) return I_SRA;
        return I_NOP;
      end
      default: return I_NOP;
    endcase
  endfunction

  task automatic m_step();
    logic [31:0] in, a, b, ii, is, ib, iu, ij, ea, w, res, nxt;
    logic [7:0]  bt;
    logic [15:0] hf;
    logic [4:0]  rd, sh;
    mnem_e       m;
    bit          wr;
    in = m_imem[m_pc[11:2]];
    m  = decode(in);
    a  = m_regs[in[19:15]];
    b  = m_regs[in[24:20]];
    rd = in[11:7];
    sh = in[24:20];
    ii = 32'($signed(in[31:20]));
    is = 32'($signed({in[31:25], in[11:7]}));
    ib = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    iu = {in[31:12], 12'h000};
    ij = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    ea = a + ((m inside {I_SB, I_SH, I_SW}) ? is : ii);
    w  = m_dmem[ea[11:2]];
    bt = w[8*ea[1:0] +: 8];
    hf = w[16*ea[1] +: 16];
    nxt = m_pc + 32'd4;
    wr  = 1'b1;
    res = '0;
    case (m)
      I_LUI:   res = iu;
      I_AUIPC: res = m_pc + iu;
      I_JAL:   begin res = m_pc + 32'd4; nxt = m_pc + ij; end
      I_JALR:  begin res = m_pc + 32'd4; nxt = (a + ii) & ~32'd1; end
      I_BEQ:   begin wr = 1'b0; if (a == b) nxt = m_pc + ib; end
      I_BNE:   begin wr = 1'b0; if (a != b) nxt = m_pc + ib; end
      I_BLT:   begin wr = 1'b0; if ($signed(a) < $signed(b)) nxt = m_pc + ib; end
      I_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) nxt = m_pc + ib; end
      I_BLTU:  begin wr = 1'b0; if (a < b) nxt = m_pc + ib; end
      I_BGEU:  begin wr = 1'b0; if (a >= b) nxt = m_pc + ib; end
      I_LB:    res = 32'($signed(bt));
      I_LH:    res = 32'($signed(hf));
      I_LW:    res = w;
      I_LBU:   res = {24'd0, bt};
      I_LHU:   res = {16'd0, hf};
      I_SB:    begin wr = 1'b0; m_dmem[ea[11:2]][8*ea[1:0] +: 8] = b[7:0]; end
      I_SH:    begin wr = 1'b0; m_dmem[ea[11:2]][16*ea[1] +: 16] = b[15:0]; end
      I_SW:    begin wr = 1'b0; m_dmem[ea[11:2]] = b; end
      I_ADDI:  res = a + ii;
      I_SLTI:  res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
      I_SLTIU: res = (a < ii) ? 32'd1 : 32'd0;
      I_XORI:  res = a ^ ii;
      I_ORI:   res = a | ii;
      I_ANDI:  res = a & ii;
      I_SLLI:  res = a << sh;
      I_SRLI:  res = a >> sh;
      I_SRAI:  res = 32'($signed(a) >>> sh);
      I_ADD:   res = a + b;
      I_SUB:   res = a - b;
      I_SLL:   res = a << b[4:0];
      I_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      I_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      I_XOR:   res = a ^ b;
      I_OR:    res = a | b;
      I_AND:   res = a & b;
      I_SRL:   res = a >> b[4:0];
      I_SRA:   res = 32'($signed(a) >>> b[4:0]);
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = nxt;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      m_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", dut.pc, m_pc);
      for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut.regs[i], m_regs[i]);
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int          off;
    rd  = 5'($urandom_range(0, 12));
    r1  = 5'($urandom_range(0, 9));
    r2  = 5'($urandom_range(0, 9));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    off = int'($urandom_range(0, 64)) - 32;
    case ($urandom_range(0, 15))
      0: return {20'($urandom), rd, 7'h37};
      1: return {20'($urandom), rd, 7'h17};
      2: return enc_j(21'(off * 4), rd);
      3: return enc_i(imm, r1, 3'd0, rd, 7'h67);
      4, 5: return enc_b(13'(off * 2), r2, r1, f3);
      6: return enc_i(12'h100 + 12'($urandom_range(0, 31)), 5'd0, f3, rd, 7'h03);
      7: return enc_s(12'h100 + 12'($urandom_range(0, 31)), r2, 5'd0, 3'($urandom_range(0, 3)));
      8, 9, 10: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          imm = {($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, 5'($urandom)};
        return enc_i(imm, r1, f3, rd, 7'h13);
      end
      11, 12, 13: return enc_r(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, r2, r1, f3, rd);
      14: case ($urandom_range(0, 2))
        0: return 32'h0000_0073;
        1: return 32'h0000_000F;
        default: return {25'($urandom), 7'h7F};
      endcase
      default: return enc_i(imm, 5'd0, 3'd0, rd, 7'h13);
    endcase
  endfunction

  task automatic emit(input logic [31:0] w);
    prog.push_back(w);
  endtask

  // Called with rst already high or about to be; unused words become NOPs.
  task automatic load_prog();
    for (int i = 0; i < 1024; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
      dut.instr_mem.mem[i] = m_imem[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic alu_prog();
    prog.delete();
    emit(32'h0050_0093);
    emit(32'hFFD0_0113);
    emit(32'h0020_81B3);
  endtask

  logic [31:0] exp_pc [5];

  initial begin
    for (int i = 0; i < 1024; i++) m_dmem[i] = '0;
    @(negedge clk);
    chk_en = 1'b1;

    // ALU
    alu_prog();
    rst = 1'b1;
    load_prog();
    do_reset();
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_x1", dut.regs[1], 32'd0);
    run(3);
    chk("alu_x1", dut.regs[1], 32'd5);
    chk("alu_x2", dut.regs[2], 32'hFFFF_FFFD);
    chk("alu_x3", dut.regs[3], 32'd2);
    chk("alu_pc", dut.pc, 32'd12);
    chk("model_alu_x2", m_regs[2], 32'hFFFF_FFFD);
    chk("model_alu_x3", m_regs[3], 32'd2);

    // Store / load
    prog.delete();
    emit(32'h7F50_0093);
    emit(32'h0010_2423);
    emit(32'h0080_0203);
    emit(32'h0090_4283);
    emit(32'h0080_2303);
    rst = 1'b1;
    load_prog();
    do_reset();
    run(5);
    chk("mem_word2", dut.data_mem.mem[2], 32'h0000_07F5);
    chk("model_mem_word2", m_dmem[2], 32'h0000_07F5);
    chk("lb_x4", dut.regs[4], 32'hFFFF_FFF5);
    chk("lbu_x5", dut.regs[5], 32'h0000_0007);
    chk("lw_x6", dut.regs[6], 32'h0000_07F5);
    chk("model_lb_x4", m_regs[4], 32'hFFFF_FFF5);

    // Branch / jump
    prog.delete();
    emit(32'h0010_0093);
    emit(32'h0000_8463);
    emit(32'h0000_9463);
    emit(32'h0550_0413);
    emit(32'h0080_03EF);
    emit(32'h0010_0493);
    emit(32'h0020_0513);
    rst = 1'b1;
    load_prog();
    do_reset();
    exp_pc = '{32'd4, 32'd8, 32'd16, 32'd24, 32'd28};
    for (int i = 0; i < 5; i++) begin
      run(1);
      chk($sformatf("br_pc%0d", i), dut.pc, exp_pc[i]);
    end
    chk("br_x7", dut.regs[7], 32'd20);
    chk("br_skip_x8", dut.regs[8], 32'd0);
    chk("br_skip_x9", dut.regs[9], 32'd0);
    chk("br_x10", dut.regs[10], 32'd2);
    chk("model_br_x7", m_regs[7], 32'd20);

    // x0 and JALR
    prog.delete();
    emit(32'h0090_0013);
    emit(32'h0200_0093);
    emit(32'h0010_80E7);
    rst = 1'b1;
    load_prog();
    do_reset();
    run(3);
    chk("x0_zero", dut.regs[0], 32'd0);
    chk("jalr_pc", dut.pc, 32'h20);
    chk("jalr_x1", dut.regs[1], 32'd12);
    run(1);
    chk("after_jalr_pc", dut.pc, 32'h24);

    // Mid-program reset
    alu_prog();
    rst = 1'b1;
    load_prog();
    do_reset();
    run(2);
    chk("pre_rst_x1", dut.regs[1], 32'd5);
    do_reset();
    chk("mid_rst_pc", dut.pc, 32'd0);
    chk("mid_rst_x1", dut.regs[1], 32'd0);
    chk("mid_rst_x2", dut.regs[2], 32'd0);
    chk("mid_rst_mem2", dut.data_mem.mem[2], 32'h0000_07F5);
    run(3);
    chk("rerun_x3", dut.regs[3], 32'd2);
    chk("rerun_pc", dut.pc, 32'd12);

    // ECALL as NOP
    prog.delete();
    emit(32'h0000_0073);
    emit(32'h0030_0093);
    rst = 1'b1;
    load_prog();
    do_reset();
    run(1);
    chk("ecall_pc", dut.pc, 32'd4);
    chk("ecall_x1", dut.regs[1], 32'd0);
    run(1);
    chk("post_ecall_x1", dut.regs[1], 32'd3);

    // Random program; loads only touch words 0x40..0x47, which the prologue fills first.
    prog.delete();
    for (int i = 0; i < 8; i++) emit(enc_i(12'($urandom), 5'd0, 3'd0, 5'(i + 1), 7'h13));
    for (int i = 0; i < 8; i++) emit(enc_s(12'(12'h100 + 4 * i), 5'(i + 1), 5'd0, 3'd2));
    while (prog.size() < 1024) emit(rand_instr());
    rst = 1'b1;
    load_prog();
    do_reset();
    run(1500);
    do_reset();
    run(1500);
    for (int i = 8'h40; i < 8'h48; i++)
      chk($sformatf("dmem%0h", i), dut.data_mem.mem[i], m_dmem[i]);
    chk("dmem2_kept", dut.data_mem.mem[2], 32'h0000_07F5);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
